pemstat_ctr_bank: RTL
=====================

Name: pemstat_ctr_bank

Overview:
- Parametrised statistics counter bank for the TSE MAC.
- Consumes the per-frame increment pulse vector produced by the statistics vector controller, and accumulates it into NUM_CNT counters of CNT_W bits each.
- Serves counter reads to the host register interface with 1-cycle latency, optional clear-on-read, wrap or saturate arithmetic, and sticky overflow flags with an interrupt.
- Successor to the fixed 44-pulse decode stage: adds storage, readout and overflow handling, generalised in count and width.

Parameters:
- NUM_CNT, 44, number of counters; must be ≥ NUM_ADD+1.
- CNT_W, 32, counter width in bits (16..64).
- NUM_ADD, 2, counters at indices 0..NUM_ADD-1 add a 16-bit value (octet counters); all other counters add 1.
- ADDR_W, 6, read address width; 2^ADDR_W ≥ NUM_CNT.
- CLR_ON_RD, 0, 1 = a read clears the counter it returns.
- SAT, 0, 1 = saturate at all-ones; 0 = wrap modulo 2^CNT_W.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- inc_vec  in  NUM_CNT  single-cycle increment strobes, bit i → counter i.
- add_val  in  16*NUM_ADD  addend for counter k taken from slice [16k+15:16k]; sampled only when inc_vec[k]=1.
- clr_all  in  1  synchronous clear of all counters and flags.
- rd_req  in  1  read request strobe.
- rd_addr  in  ADDR_W  counter index to read.
- rd_valid  out  1  read data valid, exactly 1 cycle after rd_req.
- rd_data  out  CNT_W  counter value.
- ovf_flags  out  NUM_CNT  sticky per-counter overflow flags.
- ovf_mask  in  NUM_CNT  1 = flag enabled onto irq.
- irq  out  1  registered OR of (ovf_flags & ovf_mask).

Behaviour:
- Reset, synchronous active-high: all counters, ovf_flags, rd_valid, rd_data and irq are 0. Reset dominates every other input in the same cycle.
- Update: each counter register updates every cycle as cnt_next = cnt + delta, where delta = add_val slice (zero-extended) for k<NUM_ADD, otherwise 1, and is applied only when its inc_vec bit is set. Strobes are never queued; a strobe is counted in the cycle it is high.
- Arithmetic, SAT=0: the sum is truncated to CNT_W. A carry out sets ovf_flags[i].
- Arithmetic, SAT=1: if the true sum exceeds 2^CNT_W-1, the result is all-ones and ovf_flags[i] is set. A counter already at all-ones stays there.
- Read: rd_req at cycle t latches rd_addr. At t+1, rd_valid=1 and rd_data = counter value before any t-cycle update. rd_valid is 0 in every other cycle. Back-to-back reads are legal, one per cycle.
- Out-of-range address (rd_addr ≥ NUM_CNT): rd_data=0, rd_valid still asserted, no side effects.
- Flag clear on read: a read of counter i clears ovf_flags[i] at t+1, unless an overflow on i occurs in cycle t, in which case the flag stays set.
- CLR_ON_RD=1: at t the read counter loads delta (the cycle-t increment) instead of cnt+delta, so no event is lost. The returned value excludes that delta.
- clr_all: all counters and flags become 0 at the next edge. Increments arriving in the same cycle are discarded. A read in the same cycle returns the pre-clear value.
- irq: registered, 1 cycle after the flag change. Masking does not clear flags.
- Mid-read reset: rd_valid is forced to 0 at the next edge and the pending read is dropped.

Optional Feature:
- Macro: PEMSTAT_SNAPSHOT_EN.
- When defined, adds input snap (1 bit) and a shadow bank of NUM_CNT×CNT_W registers. snap=1 copies all counters (pre-update values of that cycle) into the shadow bank atomically, and all reads then return shadow values. With CLR_ON_RD=1, snap clears the live counters to their cycle delta instead of clearing on read; reads have no clear side effect in this mode. clr_all also clears the shadow bank.
- When undefined, there is no snap port and reads return live counters as described above.

Decomposition:
- Package pemstat_pkg: STAT_IDX_* localparams naming each counter index (RX/TX octets = 0/1, frame classes etc.), default NUM_CNT/CNT_W, and the ADD_W=16 constant.
- One natural sub-module: pemstat_ctr_cell, a single counter covering the wrap/saturate adder, clear-on-read load and overflow flag. It is instantiated NUM_CNT times via generate. The top level holds the read mux, snapshot bank and irq.

Test Plan:
- Reset, then inc_vec[5] high for 3 cycles, read addr 5 → rd_valid one cycle later, rd_data=3; read addr 50 → rd_data=0.
- NUM_ADD: inc_vec[0] with add_val[15:0]=1518 twice, read 0 → 3036; CLR_ON_RD=1, read again → 0.
- CNT_W=16, SAT=0: counter 10 preloaded via 65535 increments, one more → reads 0 and ovf_flags[10]=1; with ovf_mask[10]=1, irq=1 two cycles later; read 10 → flag cleared, irq drops.
- SAT=1, same sequence → counter holds 16'hFFFF, flag set, further increments keep 16'hFFFF.
- CLR_ON_RD=1, counter 7 = 9, read 7 with inc_vec[7]=1 the same cycle → rd_data=9, next read → 1.
- clr_all with simultaneous inc_vec=all-ones and a read of 3 (value 4) → rd_data=4, afterwards all counters 0 and all flags 0. With PEMSTAT_SNAPSHOT_EN: snap, 2 more increments on 3, read 3 → snapshot value.

Source files
------------

// File: rtl/pemstat_pkg.sv
// rtl/pemstat_pkg.sv - shared constants and counter index map for the TSE MAC statistics counter bank
package pemstat_pkg;

    localparam int ADD_W       = 16;
    localparam int DEF_NUM_CNT = 44;
    localparam int DEF_CNT_W   = 32;

    localparam int STAT_IDX_RX_OCTETS    = 0;
    localparam int STAT_IDX_TX_OCTETS    = 1;
    localparam int STAT_IDX_RX_FRAMES_OK = 2;
    localparam int STAT_IDX_TX_FRAMES_OK = 3;
    localparam int STAT_IDX_RX_CRC_ERR   = 4;
    localparam int STAT_IDX_RX_UNICAST   = 5;
    localparam int STAT_IDX_RX_MULTICAST = 6;
    localparam int STAT_IDX_RX_BROADCAST = 7;
    localparam int STAT_IDX_TX_UNICAST   = 8;
    localparam int STAT_IDX_TX_MULTICAST = 9;
    localparam int STAT_IDX_RX_FRAGMENTS = 10;
    localparam int STAT_IDX_RX_JABBERS   = 11;
    localparam int STAT_IDX_RX_PAUSE     = 12;
    localparam int STAT_IDX_TX_PAUSE     = 13;

    typedef enum logic {
        ARITH_WRAP = 1'b0,
        ARITH_SAT  = 1'b1
    } arith_mode_e;

endpackage

// File: rtl/pemstat_ctr_cell.sv
// rtl/pemstat_ctr_cell.sv - one statistics counter: wrap/saturate adder, clear-on-read load, sticky overflow flag
module pemstat_ctr_cell
    import pemstat_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SAT    = 0,
    parameter int IS_ADD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic [ADD_W-1:0] add_val_i,
    input  logic             clr_all_i,
    input  logic             ld_delta_i,
    input  logic             flag_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam arith_mode_e MODE = (SAT != 0) ? ARITH_SAT : ARITH_WRAP;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] delta;
    logic [CNT_W:0]   sum;
    logic             carry;
    logic             ovf_q, ovf_d;

    always_comb begin
        delta = '0;
        if (inc_i) begin
            delta = (IS_ADD != 0) ? CNT_W'(add_val_i) : CNT_W'(1);
        end
        sum   = {1'b0, cnt_q} + {1'b0, delta};
        // A load of the bare delta can never carry, so it never raises the flag.
        carry = sum[CNT_W] & ~ld_delta_i;
        if (ld_delta_i) begin
            cnt_d = delta;
        end else if (carry && (MODE == ARITH_SAT)) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
        ovf_d = (ovf_q & ~flag_clr_i) | carry;
    end

    always_ff @(posedge clk) begin
        if (reset || clr_all_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pemstat_ctr_bank.sv
// rtl/pemstat_ctr_bank.sv - statistics counter bank with read mux and irq; PEMSTAT_SNAPSHOT_EN adds a snapshot shadow bank
module pemstat_ctr_bank
    import pemstat_pkg::*;
#(
    parameter int NUM_CNT   = DEF_NUM_CNT,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int NUM_ADD   = 2,
    parameter int ADDR_W    = 6,
    parameter int CLR_ON_RD = 0,
    parameter int SAT       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CNT-1:0]       inc_vec,
    input  logic [ADD_W*NUM_ADD-1:0] add_val,
    input  logic                     clr_all,
`ifdef PEMSTAT_SNAPSHOT_EN
    input  logic                     snap,
`endif
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_data,
    output logic [NUM_CNT-1:0]       ovf_flags,
    input  logic [NUM_CNT-1:0]       ovf_mask,
    output logic                     irq
);

    logic [NUM_CNT-1:0] rd_hit;
    logic [NUM_CNT-1:0] ld_delta;
    logic [CNT_W-1:0]   cnt    [NUM_CNT];
    logic [CNT_W-1:0]   rd_src [NUM_CNT];
    logic [CNT_W-1:0]   rd_mux;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   rd_data_q;
    logic               irq_q;

    // Out-of-range addresses hit no counter, which yields zero data and no side effect.
    always_comb begin
        rd_hit = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            rd_hit[i] = rd_req && (rd_addr == ADDR_W'(i));
        end
    end

`ifdef PEMSTAT_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_q [NUM_CNT];

    always_ff @(posedge clk) begin
        if (reset || clr_all) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
        end else if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt[i];
        end
    end

    assign ld_delta = {NUM_CNT{snap && (CLR_ON_RD != 0)}};
    assign rd_src   = shadow_q;
`else
    assign ld_delta = (CLR_ON_RD != 0) ? rd_hit : '0;
    assign rd_src   = cnt;
`endif

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_hit[i]) rd_mux = rd_src[i];
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
        logic [ADD_W-1:0] cell_add;
        if (g < NUM_ADD) begin : g_add
            assign cell_add = add_val[g*ADD_W +: ADD_W];
        end else begin : g_one
            assign cell_add = '0;
        end

        pemstat_ctr_cell #(
            .CNT_W  (CNT_W),
            .SAT    (SAT),
            .IS_ADD ((g < NUM_ADD) ? 1 : 0)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .inc_i      (inc_vec[g]),
            .add_val_i  (cell_add),
            .clr_all_i  (clr_all),
            .ld_delta_i (ld_delta[g]),
            .flag_clr_i (rd_hit[g]),
            .cnt_o      (cnt[g]),
            .ovf_o      (ovf_flags[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) rd_data_q <= rd_mux;
            irq_q      <= |(ovf_flags & ovf_mask);
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign irq      = irq_q;

endmodule
